// File: rtl/shifter_arbiter.sv
// Two-port arbiter and sequencer in front of a shared combinational 32-bit barrel shifter.
// Define SHIFTER_ROTATE_EN to build rotate-right (Op=11) as two shifter passes; otherwise Op=11 behaves as SRL.
module shifter_arbiter (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0_Valid,
  output logic        Req0_Ready,
  input  logic [31:0] Req0_X,
  input  logic [4:0]  Req0_Sa,
  input  logic [1:0]  Req0_Op,
  input  logic        Req1_Valid,
  output logic        Req1_Ready,
  input  logic [31:0] Req1_X,
  input  logic [4:0]  Req1_Sa,
  input  logic [1:0]  Req1_Op,
  output logic        Resp_Valid,
  input  logic        Resp_Ready,
  output logic [31:0] Resp_Data,
  output logic        Resp_Id,
  output logic [31:0] Sh_X,
  output logic [4:0]  Sh_Sa,
  output logic        Sh_Arith,
  output logic        Sh_Right,
  input  logic [31:0] Sh_Result
);

  typedef enum logic [1:0] {IDLE, EXEC, ROT2, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [31:0] res_q, res_d;
  // Sh_X/Sh_Sa registers double as the latched operands while a command is in flight.
  logic [31:0] sh_x_q, sh_x_d;
  logic [4:0]  sh_sa_q, sh_sa_d;
  logic        sh_arith_q, sh_arith_d;
  logic        sh_right_q, sh_right_d;
`ifdef SHIFTER_ROTATE_EN
  logic        rot_q, rot_d;
`endif

  logic        grant0, grant1, accept, acc_id;
  logic [31:0] acc_x;
  logic [4:0]  acc_sa;
  logic [1:0]  acc_op;

  // last_q names the port granted most recently; a tie goes to the other one.
  always_comb begin
    grant0     = Req0_Valid & (~Req1_Valid | last_q);
    grant1     = Req1_Valid & (~Req0_Valid | ~last_q);
    Req0_Ready = (state_q == IDLE) & grant0;
    Req1_Ready = (state_q == IDLE) & grant1;
    accept     = Req0_Ready | Req1_Ready;
    acc_id     = Req1_Ready;
    acc_x      = acc_id ? Req1_X  : Req0_X;
    acc_sa     = acc_id ? Req1_Sa : Req0_Sa;
    acc_op     = acc_id ? Req1_Op : Req0_Op;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    res_d      = res_q;
    sh_x_d     = '0;
    sh_sa_d    = '0;
    sh_arith_d = 1'b0;
    sh_right_d = 1'b0;
`ifdef SHIFTER_ROTATE_EN
    rot_d      = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = EXEC;
          last_d     = acc_id;
          id_d       = acc_id;
          sh_x_d     = acc_x;
          sh_sa_d    = acc_sa;
          sh_right_d = (acc_op != 2'b00);
          sh_arith_d = (acc_op == 2'b10);
`ifdef SHIFTER_ROTATE_EN
          rot_d      = (acc_op == 2'b11);
`endif
        end
      end
      EXEC: begin
        res_d   = Sh_Result;
        state_d = DONE;
`ifdef SHIFTER_ROTATE_EN
        // Second pass supplies the bits wrapped around: X << (32 - Sa).
        if (rot_q && (sh_sa_q != 5'd0)) begin
          state_d = ROT2;
          sh_x_d  = sh_x_q;
          sh_sa_d = 5'd0 - sh_sa_q;
        end
`endif
      end
`ifdef SHIFTER_ROTATE_EN
      ROT2: begin
        res_d   = res_q | Sh_Result;
        state_d = DONE;
      end
`endif
      DONE: begin
        if (Resp_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      res_q      <= '0;
      sh_x_q     <= '0;
      sh_sa_q    <= '0;
      sh_arith_q <= 1'b0;
      sh_right_q <= 1'b0;
`ifdef SHIFTER_ROTATE_EN
      rot_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      res_q      <= res_d;
      sh_x_q     <= sh_x_d;
      sh_sa_q    <= sh_sa_d;
      sh_arith_q <= sh_arith_d;
      sh_right_q <= sh_right_d;
`ifdef SHIFTER_ROTATE_EN
      rot_q      <= rot_d;
`endif
    end
  end

  assign Resp_Valid = (state_q == DONE);
  assign Resp_Data  = res_q;
  assign Resp_Id    = id_q;
  assign Sh_X       = sh_x_q;
  assign Sh_Sa      = sh_sa_q;
  assign Sh_Arith   = sh_arith_q;
  assign Sh_Right   = sh_right_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: behavioural shifter attached to Sh_*, directed cases plus random commands
// checked against an arithmetic reference model.
module tb_shifter_arbiter;

`ifdef SHIFTER_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req0_Valid, Req1_Valid, Req0_Ready, Req1_Ready;
  logic [31:0] Req0_X, Req1_X;
  logic [4:0]  Req0_Sa, Req1_Sa;
  logic [1:0]  Req0_Op, Req1_Op;
  logic        Resp_Valid, Resp_Ready, Resp_Id;
  logic [31:0] Resp_Data;
  logic [31:0] Sh_X, Sh_Result;
  logic [4:0]  Sh_Sa;
  logic        Sh_Arith, Sh_Right;

  int checks = 0;
  int fails  = 0;

  always #5 Clk = ~Clk;

  shifter_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_X(Req0_X), .Req0_Sa(Req0_Sa), .Req0_Op(Req0_Op),
    .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_X(Req1_X), .Req1_Sa(Req1_Sa), .Req1_Op(Req1_Op),
    .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready), .Resp_Data(Resp_Data), .Resp_Id(Resp_Id),
    .Sh_X(Sh_X), .Sh_Sa(Sh_Sa), .Sh_Arith(Sh_Arith), .Sh_Right(Sh_Right), .Sh_Result(Sh_Result)
  );

  // Stand-in for the shared combinational barrel shifter.
  logic signed [31:0] sx;
  logic [31:0]        sra_r;
  always_comb begin
    sx    = Sh_X;
    sra_r = sx >>> Sh_Sa;
  end
  assign Sh_Result = !Sh_Right ? (Sh_X << Sh_Sa) : (Sh_Arith ? sra_r : (Sh_X >> Sh_Sa));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] sa, input logic [1:0] op);
    logic [63:0] w;
    case (op)
      2'b00: w = {32'b0, x << sa};
      2'b01: w = {32'b0, x} >> sa;
      2'b10: w = {{32{x[31]}}, x} >> sa;
      default: w = ROT_EN ? ({x, x} >> sa) : ({32'b0, x} >> sa);
    endcase
    return w[31:0];
  endfunction

  task automatic set_req(input int p, input logic v, input logic [31:0] x, input logic [4:0] sa, input logic [1:0] op);
    if (p == 0) begin Req0_Valid = v; Req0_X = x; Req0_Sa = sa; Req0_Op = op; end
    else        begin Req1_Valid = v; Req1_X = x; Req1_Sa = sa; Req1_Op = op; end
  endtask

  task automatic tick();
    @(posedge Clk); #2;
  endtask

  // Expects the DUT idle; issues one command, checks grant, shifter drive, latency and response.
  task automatic run_cmd(input int p, input logic [31:0] x, input logic [4:0] sa, input logic [1:0] op,
                         input logic [31:0] exp);
    int lat;
    bit rot;
    rot = ROT_EN && (op == 2'b11) && (sa != 5'd0);
    set_req(p, 1'b1, x, sa, op);
    #1;
    chk("ready_own",   32'(p == 0 ? Req0_Ready : Req1_Ready), 32'd1);
    chk("ready_other", 32'(p == 0 ? Req1_Ready : Req0_Ready), 32'd0);
    tick();
    set_req(p, 1'b0, x, sa, op);
    chk("exec_sh_x",     Sh_X, x);
    chk("exec_sh_sa",    32'(Sh_Sa), 32'(sa));
    chk("exec_sh_right", 32'(Sh_Right), 32'(op != 2'b00));
    chk("exec_sh_arith", 32'(Sh_Arith), 32'(op == 2'b10));
    chk("exec_resp_v",   32'(Resp_Valid), 32'd0);
    lat = 1;
    while (!Resp_Valid && lat < 10) begin
      tick();
      lat++;
      if (rot && lat == 2) begin
        chk("rot2_sh_sa",    32'(Sh_Sa), 32'((32 - int'(sa)) % 32));
        chk("rot2_sh_right", 32'(Sh_Right), 32'd0);
        chk("rot2_sh_x",     Sh_X, x);
      end
    end
    chk("latency",   32'(lat), rot ? 32'd3 : 32'd2);
    chk("resp_data", Resp_Data, exp);
    chk("resp_id",   32'(Resp_Id), 32'(p));
    chk("done_sh_x", Sh_X, 32'd0);
    Resp_Ready = 1'b1;
    tick();
    Resp_Ready = 1'b0;
    chk("resp_drop", 32'(Resp_Valid), 32'd0);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
  endtask

  initial begin
    int   rem0, rem1, both, lat;
    int   g[$];
    int   ids[$];
    logic [31:0] dat[$];
    logic [31:0] hold;
    Rst = 1'b1;
    Resp_Ready = 1'b0;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    chk("rst_resp_v", 32'(Resp_Valid), 32'd0);
    chk("rst_resp_d", Resp_Data, 32'd0);
    chk("rst_resp_id", 32'(Resp_Id), 32'd0);
    chk("rst_sh", {Sh_X[26:0], Sh_Sa}, 32'd0);
    chk("rst_sh_ctl", 32'({Sh_Arith, Sh_Right}), 32'd0);

    run_cmd(0, 32'h0000_0001, 5'd4, 2'b00, 32'h0000_0010);
    run_cmd(1, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
    run_cmd(1, 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
    run_cmd(0, 32'h1234_5678, 5'd8, 2'b11, ROT_EN ? 32'h7812_3456 : 32'h0012_3456);
    run_cmd(1, 32'h1234_5678, 5'd0, 2'b11, 32'h1234_5678);
    run_cmd(0, 32'hF0F0_1234, 5'd0, 2'b10, 32'hF0F0_1234);

    // Backpressure: response held while Req0 has another command pending.
    set_req(0, 1'b1, 32'hA5A5_0001, 5'd1, 2'b00);
    tick();
    set_req(0, 1'b1, 32'h0000_00F0, 5'd4, 2'b01);
    lat = 0;
    while (!Resp_Valid && lat < 10) begin
      chk("bp_busy_ready", 32'(Req0_Ready), 32'd0);
      tick();
      lat++;
    end
    hold = 32'h4B4A_0002;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(Resp_Valid), 32'd1);
      chk("bp_data",  Resp_Data, hold);
      chk("bp_ready", 32'(Req0_Ready), 32'd0);
      tick();
    end
    Resp_Ready = 1'b1;
    tick();
    Resp_Ready = 1'b0;
    chk("bp_idle_ready", 32'(Req0_Ready), 32'd1);
    tick();
    set_req(0, 1'b0, 32'h0000_00F0, 5'd4, 2'b01);
    lat = 1;
    while (!Resp_Valid && lat < 10) begin tick(); lat++; end
    chk("bp_lat2",  32'(lat), 32'd2);
    chk("bp_data2", Resp_Data, 32'h0000_000F);
    Resp_Ready = 1'b1;
    tick();
    Resp_Ready = 1'b0;

    for (int n = 0; n < 40; n++) begin
      int          p;
      logic [31:0] x;
      logic [4:0]  sa;
      logic [1:0]  op;
      p  = int'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      sa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      x  = $urandom;
      run_cmd(p, x, sa, op, ref_shift(x, sa, op));
    end

    // Both requesters contend after reset: grants must alternate starting with 0.
    do_reset();
    rem0 = 2; rem1 = 1; both = 0;
    Resp_Ready = 1'b1;
    Req0_X = 32'd1; Req0_Sa = 5'd0; Req0_Op = 2'b00;
    Req1_X = 32'd2; Req1_Sa = 5'd0; Req1_Op = 2'b00;
    for (int c = 0; c < 20; c++) begin
      Req0_Valid = (rem0 > 0);
      Req1_Valid = (rem1 > 0);
      #1;
      if (Req0_Ready && Req1_Ready) both++;
      if (Req0_Ready) begin g.push_back(0); rem0--; end
      else if (Req1_Ready) begin g.push_back(1); rem1--; end
      if (Resp_Valid) begin ids.push_back(int'(Resp_Id)); dat.push_back(Resp_Data); end
      tick();
    end
    Req0_Valid = 1'b0; Req1_Valid = 1'b0; Resp_Ready = 1'b0;
    chk("arb_both_ready", 32'(both), 32'd0);
    chk("arb_grants", 32'(g.size()), 32'd3);
    chk("arb_order", 32'({g[0][0], g[1][0], g[2][0]}), 32'b010);
    chk("arb_resps", 32'(ids.size()), 32'd3);
    chk("arb_ids", 32'({ids[0][0], ids[1][0], ids[2][0]}), 32'b010);
    chk("arb_data", {dat[0][7:0], dat[1][7:0], dat[2][7:0], 8'h0}, 32'h0102_0100);

    // Reset while a command is in EXEC: everything clears at once, no response follows.
    set_req(0, 1'b1, 32'hDEAD_BEEF, 5'd3, 2'b01);
    tick();
    set_req(0, 1'b0, 32'hDEAD_BEEF, 5'd3, 2'b01);
    chk("rx_exec_sh_x", Sh_X, 32'hDEAD_BEEF);
    Rst = 1'b1;
    #1;
    chk("rx_sh_x", Sh_X, 32'd0);
    chk("rx_sh_ctl", 32'({Sh_Sa, Sh_Arith, Sh_Right}), 32'd0);
    chk("rx_resp", 32'({Resp_Valid, Resp_Id}), 32'd0);
    chk("rx_resp_d", Resp_Data, 32'd0);
    #1;
    Rst = 1'b0;
    Resp_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rx_no_resp", 32'(Resp_Valid), 32'd0);
    end
    Resp_Ready = 1'b0;
    set_req(0, 1'b1, 32'h0000_0003, 5'd1, 2'b00);
    set_req(1, 1'b1, 32'h0000_0005, 5'd1, 2'b00);
    #1;
    chk("rx_tie_r0", 32'(Req0_Ready), 32'd1);
    chk("rx_tie_r1", 32'(Req1_Ready), 32'd0);
    tick();
    set_req(0, 1'b0, 32'h0000_0003, 5'd1, 2'b00);
    set_req(1, 1'b0, 32'h0000_0005, 5'd1, 2'b00);
    lat = 1;
    while (!Resp_Valid && lat < 10) begin tick(); lat++; end
    chk("rx_tie_data", Resp_Data, 32'h0000_0006);
    chk("rx_tie_id", 32'(Resp_Id), 32'd0);
    Resp_Ready = 1'b1;
    tick();
    Resp_Ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
